prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader that sits directly upstream of the accumulator CPU. It receives a 32-byte program image over a UART-style 8N1 line and writes it byte-by-byte into the CPU's 32×8 instruction memory. It holds the CPU in reset until the image is complete, then releases it. It is the only writer of instruction memory in the design.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 4..255.
- DEPTH, 32: bytes per program image; equals instruction-memory depth.
- AW, 5: address width; DEPTH = 2^AW.

- clk_i  in  1  system clock, single clock domain; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_i  in  1  serial data in; idle high; asynchronous to clk_i.
- mem_we_o  out  1  instruction-memory write strobe, one-cycle pulse per accepted byte.
- mem_addr_o  out  AW  write address.
- mem_data_o  out  8  write data.
- cpu_rst_o  out  1  active-high reset to the CPU; high while loading.
- done_o  out  1  high once the image is loaded and the CPU is released.
- frame_err_o  out  1  sticky flag; a stop bit sampled low.
- cksum_err_o  out  1  sticky flag; checksum mismatch (only with the macro; otherwise tied 0).

## Operation
- rx_i passes through a 2-flop synchronizer; both flops reset to 1.
- Receiver FSM:
  - IDLE -> START on a synchronized falling edge (1 then 0).
  - START: wait CLKS_PER_BIT/2 (integer division) cycles, then resample. If the line is 0, go to DATA. If it is 1, the start was a glitch; return to IDLE with nothing recorded.
  - DATA: sample 8 bits, LSB first, one every CLKS_PER_BIT cycles.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE.
- Stop bit = 1: the byte is accepted.
  - With the FSM in LOAD, the next cycle places the byte on mem_data_o and mem_addr_o and pulses mem_we_o.
  - The address increments after the write.
- Stop bit = 0: the byte is discarded, frame_err_o is set, the address does not advance, and reception continues.
- Loader FSM:
  - LOAD: accept bytes. Write at address DEPTH-1 -> RUN (CHECK with the macro).
  - RUN: cpu_rst_o = 0 and done_o = 1. Further serial bytes are received but ignored: no write, no state change. Only rst_i leaves RUN.
- Address is AW bits and never wraps during LOAD, because the transition out of LOAD happens on the write to DEPTH-1.
- mem_addr_o and mem_data_o hold their last values between strobes.

## Timing
- Reset values: mem_we_o 0, mem_addr_o 0, mem_data_o 0x00, cpu_rst_o 1, done_o 0, frame_err_o 0, cksum_err_o 0; both FSMs in their initial states (IDLE, LOAD).
- Latency from a rx_i edge to the FSM seeing it: 2 cycles (synchronizer).
- The mem_we_o pulse occurs exactly 1 cycle after the stop-bit sample.
- Final-byte write sequence:
  - cycle N: mem_we_o pulse for address DEPTH-1.
  - cycle N+1: cpu_rst_o falls and done_o rises in the same cycle, so the CPU's first fetch sees the complete image.
- rst_i asserted mid-frame or mid-image: everything returns immediately to reset values. The partial image is left in memory and is overwritten by the next load. cpu_rst_o rises asynchronously.
- A start edge arriving while in STOP is ignored. Detection resumes in IDLE on the next falling edge.

## Configuration
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After byte DEPTH-1, the loader enters CHECK and expects one more byte: the two's-complement checksum. The sum mod 256 of all DEPTH image bytes plus the checksum byte must be 0x00.
  - Match -> RUN on the cycle after the stop-bit sample, with the same cpu_rst_o/done_o timing as above.
  - Mismatch -> cksum_err_o is set, address returns to 0, and the FSM returns to LOAD (reload expected). cpu_rst_o stays 1.
  - The checksum byte is never written to memory.
  - A framing error on the checksum byte leaves the FSM in CHECK.
- Not defined:
  - There is no CHECK state; LOAD -> RUN directly after byte DEPTH-1.
  - cksum_err_o is constant 0.

## Test plan
All scenarios use CLKS_PER_BIT=16 unless noted.
- Reset: assert rst_i mid-cycle -> all outputs at reset values immediately; cpu_rst_o=1.
- Full load (macro off): send bytes 0x00..0x1F.
  - Expect 32 mem_we_o pulses, each with mem_data_o equal to mem_addr_o.
  - The cycle after the last pulse: cpu_rst_o=0, done_o=1.
  - A 33rd byte 0xAA produces no pulse.
- Framing error: send 0x55 with stop bit = 0, then 0x33.
  - frame_err_o=1.
  - A single pulse occurs: addr 0, data 0x33.
- Glitch: drive rx_i low for 3 cycles -> no byte received; receiver back in IDLE; addr stays 0.
- Mid-load reset: load 10 bytes, assert rst_i, then send 32 bytes 0xFF.
  - Addresses restart at 0.
  - done_o=1 after 32 writes.
- Checksum (macro on):
  - 32 bytes of 0x01 then checksum 0xE0 -> RUN.
  - 32 bytes of 0x01 then checksum 0xE1 -> cksum_err_o=1, cpu_rst_o=1, next write at addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a DEPTH-byte program image over an 8N1 serial line,
// writes it into instruction memory and holds the CPU in reset until the
// image is complete.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing
// two's-complement checksum byte before the CPU is released.
module prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 32,
    parameter int AW           = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_data_o,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          frame_err_o,
    output logic          cksum_err_o
);

    localparam logic [7:0]    BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    HALF_LAST = 8'((CLKS_PER_BIT / 2) - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_LOAD  = 2'd0,
        LD_RUN   = 2'd1,
        LD_CHECK = 2'd2
    } ld_state_t;

    // synchronizer and edge-detect history
    logic sync1, sync2, sync_prev;

    // receiver state
    rx_state_t rx_state, rx_next;
    logic [7:0] cnt, cnt_next;
    logic [2:0] bit_idx, bit_next;
    logic [7:0] rx_shift, shift_next;
    logic       rx_valid, valid_next;
    logic       ferr_set;

    // loader state
    ld_state_t ld_state, ld_next;
    logic [AW-1:0] wr_addr, addr_next;
    logic          do_write;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum, sum_next, ck_total;
    logic       ck_fail;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_i;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Receiver next-state: start detection, mid-bit sampling, stop check.
    always_comb begin
        rx_next    = rx_state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = rx_shift;
        valid_next = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_next = 8'd0;
                bit_next = 3'd0;
                if (sync_prev && !sync2) begin
                    rx_next = RX_START;
                end else begin
                    rx_next = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = 8'd0;
                    // a line already back high means the edge was a glitch
                    if (!sync2) begin
                        rx_next = RX_DATA;
                    end else begin
                        rx_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = 8'd0;
                    shift_next = {sync2, rx_shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        rx_next = RX_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = 8'd0;
                    rx_next  = RX_IDLE;
                    if (sync2) begin
                        valid_next = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                rx_next  = RX_IDLE;
                cnt_next = 8'd0;
            end
        endcase
    end

    // Receiver registers and sticky framing-error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state    <= RX_IDLE;
            cnt         <= 8'd0;
            bit_idx     <= 3'd0;
            rx_shift    <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_state <= rx_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_next;
            rx_shift <= shift_next;
            rx_valid <= valid_next;
            if (ferr_set) begin
                frame_err_o <= 1'b1;
            end
        end
    end

    // Loader next-state: write accepted bytes and decide when to release the CPU.
    always_comb begin
        ld_next   = ld_state;
        do_write  = 1'b0;
        addr_next = wr_addr;
`ifdef LOADER_CHECKSUM_EN
        sum_next  = sum;
        ck_fail   = 1'b0;
        ck_total  = sum + rx_shift;
`endif
        case (ld_state)
            LD_LOAD: begin
                if (rx_valid) begin
                    do_write  = 1'b1;
                    addr_next = wr_addr + AW'(1'b1);
`ifdef LOADER_CHECKSUM_EN
                    sum_next  = sum + rx_shift;
`endif
                    if (wr_addr == ADDR_LAST) begin
`ifdef LOADER_CHECKSUM_EN
                        ld_next = LD_CHECK;
`else
                        ld_next = LD_RUN;
`endif
                    end else begin
                        ld_next = LD_LOAD;
                    end
                end else begin
                    ld_next = LD_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (rx_valid) begin
                    if (ck_total == 8'h00) begin
                        ld_next = LD_RUN;
                    end else begin
                        // bad image: restart the load from address 0
                        ck_fail   = 1'b1;
                        addr_next = '0;
                        sum_next  = 8'h00;
                        ld_next   = LD_LOAD;
                    end
                end else begin
                    ld_next = LD_CHECK;
                end
            end
`endif
            LD_RUN: begin
                ld_next = LD_RUN;
            end
            default: begin
                ld_next = LD_LOAD;
            end
        endcase
    end

    // Loader registers; CPU release lags the state change by one cycle so the
    // final write lands before the CPU's first fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_state   <= LD_LOAD;
            wr_addr    <= '0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= 8'h00;
            cpu_rst_o  <= 1'b1;
            done_o     <= 1'b0;
        end else begin
            ld_state <= ld_next;
            wr_addr  <= addr_next;
            mem_we_o <= do_write;
            if (do_write) begin
                mem_addr_o <= wr_addr;
                mem_data_o <= rx_shift;
            end
            cpu_rst_o <= (ld_state != LD_RUN);
            done_o    <= (ld_state == LD_RUN);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running image sum and sticky checksum-error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum         <= 8'h00;
            cksum_err_o <= 1'b0;
        end else begin
            sum <= sum_next;
            if (ck_fail) begin
                cksum_err_o <= 1'b1;
            end
        end
    end
`else
    assign cksum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (CLKS_PER_BIT = 16, DEPTH = 32).
module tb_prog_loader;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst;
    logic       done;
    logic       frame_err;
    logic       cksum_err;

    int tests = 0;
    int fails = 0;

    logic [4:0] wa[$];
    logic [7:0] wd[$];
    logic       last_seen  = 1'b0;
    logic       pulse_rst  = 1'bx;
    logic       pulse_done = 1'bx;
    logic       after_rst  = 1'bx;
    logic       after_done = 1'bx;

    prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(32), .AW(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .cpu_rst_o   (cpu_rst),
        .done_o      (done),
        .frame_err_o (frame_err),
        .cksum_err_o (cksum_err)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every strobe and the release timing around address 31.
    always @(negedge clk) begin
        if (last_seen) begin
            after_rst  = cpu_rst;
            after_done = done;
            last_seen  = 1'b0;
        end
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            if (mem_addr == 5'd31) begin
                pulse_rst  = cpu_rst;
                pulse_done = done;
                last_seen  = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int bad;

        // reset values while rst is held
        repeat (3) @(negedge clk);
        #2;
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_data",  32'(mem_data),  32'h00);
        chk("rst_cpu",   32'(cpu_rst),   32'd1);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ckerr", 32'(cksum_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // glitch: 3-cycle low pulse must not produce a byte
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_cnt",  32'(wa.size()), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        chk("glitch_addr", 32'(mem_addr),  32'd0);

        // framing error then a good byte
        send_byte(8'h55, 1'b0);
        chk("ferr_flag", 32'(frame_err),  32'd1);
        chk("ferr_cnt",  32'(wa.size()),  32'd0);
        send_byte(8'h33, 1'b1);
        chk("ferr_cnt2", 32'(wa.size()),  32'd1);
        chk("ferr_addr", 32'(wa[0]),      32'd0);
        chk("ferr_data", 32'(wd[0]),      32'h33);

        // nine more bytes: ten in the partial image
        for (int i = 1; i < 10; i++) begin
            send_byte(8'(i + 8'h40), 1'b1);
        end
        chk("part_cnt",  32'(wa.size()), 32'd10);
        chk("part_addr", 32'(mem_addr),  32'd9);
        chk("part_data", 32'(mem_data),  32'h49);
        chk("part_cpu",  32'(cpu_rst),   32'd1);
        chk("part_done", 32'(done),      32'd0);

        // reset in the middle of a frame
        @(negedge clk);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_addr", 32'(mem_addr),  32'd0);
        chk("mid_data", 32'(mem_data),  32'h00);
        chk("mid_ferr", 32'(frame_err), 32'd0);
        chk("mid_cpu",  32'(cpu_rst),   32'd1);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // full load of 0xFF: addresses restart from 0
        base = wa.size();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'hFF, 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h20, 1'b1);
`endif
        chk("ff_cnt",   32'(wa.size() - base), 32'd32);
        chk("ff_first", 32'(wa[base]),         32'd0);
        chk("ff_last",  32'(wa[base + 31]),    32'd31);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (wd[base + i] !== 8'hFF || wa[base + i] !== 5'(i)) bad++;
        end
        chk("ff_bad",  32'(bad),     32'd0);
        chk("ff_done", 32'(done),    32'd1);
        chk("ff_cpu",  32'(cpu_rst), 32'd0);

        // full load of 0x00..0x1F with release timing
        pulse_reset();
        pulse_rst  = 1'bx;
        pulse_done = 1'bx;
        after_rst  = 1'bx;
        after_done = 1'bx;
        base = wa.size();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i), 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        chk("seq_pre_done", 32'(done), 32'd0);
        send_byte(8'h10, 1'b1);
`else
        chk("seq_pulse_cpu",  32'(pulse_rst),  32'd1);
        chk("seq_pulse_done", 32'(pulse_done), 32'd0);
        chk("seq_after_cpu",  32'(after_rst),  32'd0);
        chk("seq_after_done", 32'(after_done), 32'd1);
`endif
        chk("seq_cnt", 32'(wa.size() - base), 32'd32);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (wa[base + i] !== 5'(i) || wd[base + i] !== 8'(i)) bad++;
        end
        chk("seq_bad",  32'(bad),     32'd0);
        chk("seq_done", 32'(done),    32'd1);
        chk("seq_cpu",  32'(cpu_rst), 32'd0);

        // extra byte in RUN is ignored; outputs hold
        send_byte(8'hAA, 1'b1);
        chk("run_cnt",  32'(wa.size() - base), 32'd32);
        chk("run_done", 32'(done),     32'd1);
        chk("run_addr", 32'(mem_addr), 32'd31);
        chk("run_data", 32'(mem_data), 32'h1F);

        // reset while running raises cpu_rst immediately
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cpu",  32'(cpu_rst), 32'd1);
        chk("arst_done", 32'(done),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef LOADER_CHECKSUM_EN
        // good checksum
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h01, 1'b1);
        end
        send_byte(8'hE0, 1'b1);
        chk("ck_ok_done", 32'(done),      32'd1);
        chk("ck_ok_err",  32'(cksum_err), 32'd0);

        // bad checksum forces a reload from address 0
        pulse_reset();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h01, 1'b1);
        end
        base = wa.size();
        send_byte(8'hE1, 1'b1);
        chk("ck_bad_err",  32'(cksum_err),        32'd1);
        chk("ck_bad_cpu",  32'(cpu_rst),          32'd1);
        chk("ck_bad_done", 32'(done),             32'd0);
        chk("ck_no_write", 32'(wa.size() - base), 32'd0);
        send_byte(8'h42, 1'b1);
        chk("ck_re_addr", 32'(mem_addr), 32'd0);
        chk("ck_re_data", 32'(mem_data), 32'h42);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
